// File: rtl/fire_alarm_zone_controller.sv
// Multi-zone fire alarm controller: per-zone threshold/confirm filters feeding a global
// IDLE/WARN/ALARM/EVAC FSM with evacuation countdown, blink and sounder. Option: FA_MANUAL_CALL_EN.
module fire_alarm_zone_controller #(
    parameter int unsigned NUM_ZONES   = 4,
    parameter int unsigned TEMP_W      = 8,
    parameter int unsigned WARN_TH     = 40,
    parameter int unsigned ALARM_TH    = 50,
    parameter int unsigned CONFIRM_N   = 3,
    parameter int unsigned COUNTDOWN_S = 10,
    parameter int unsigned TICK_DIV    = 100_000_000,
    parameter int unsigned BLINK_DIV   = 50_000_000
) (
    input  logic                        clk_in,
    input  logic                        reset,
    input  logic [NUM_ZONES*TEMP_W-1:0] temp_in,
    input  logic [NUM_ZONES-1:0]        temp_valid,
    input  logic                        ack,
`ifdef FA_MANUAL_CALL_EN
    input  logic                        manual_call,
    output logic                        manual_flag,
`endif
    output logic [1:0]                  state,
    output logic [NUM_ZONES-1:0]        alarm_zone,
    output logic [7:0]                  countdown,
    output logic                        led_out,
    output logic                        buzzer_out,
    output logic                        evac_out
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WARN  = 2'b01;
    localparam logic [1:0] ST_ALARM = 2'b10;
    localparam logic [1:0] ST_EVAC  = 2'b11;

    localparam int unsigned CNT_W   = $clog2(CONFIRM_N + 1);
    localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(CONFIRM_N);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [TEMP_W-1:0]  WARN_T     = TEMP_W'(WARN_TH);
    localparam logic [TEMP_W-1:0]  ALARM_T    = TEMP_W'(ALARM_TH);
    localparam logic [7:0]         CD_LOAD    = 8'(COUNTDOWN_S);

    logic [NUM_ZONES-1:0] warm_q, hot_q, trip;
    logic [CNT_W-1:0]     cnt_q [NUM_ZONES];
    logic                 any_warm, any_hot, any_trip;

    logic [1:0]           state_q, state_d;
    logic [7:0]           countdown_q, countdown_d;
    logic [NUM_ZONES-1:0] alarm_zone_q, alarm_zone_d;
    logic                 enter_alarm, enter_idle;

    logic [TICK_W-1:0]    tick_cnt_q;
    logic [BLINK_W-1:0]   blink_cnt_q;
    logic                 tick, phase_q;
    logic                 led_q, buzzer_q, evac_q;
    logic                 man_rise;

    // Zone filters: flags and confirm counters only move on a strobe.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            warm_q <= '0;
            hot_q  <= '0;
            cnt_q  <= '{default: '0};
        end else begin
            for (int i = 0; i < int'(NUM_ZONES); i++) begin
                if (temp_valid[i]) begin
                    warm_q[i] <= temp_in[i*TEMP_W +: TEMP_W] >= WARN_T;
                    hot_q[i]  <= temp_in[i*TEMP_W +: TEMP_W] >= ALARM_T;
                    if (temp_in[i*TEMP_W +: TEMP_W] >= ALARM_T) begin
                        cnt_q[i] <= (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + 1'b1;
                    end else begin
                        cnt_q[i] <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        trip = '0;
        for (int i = 0; i < int'(NUM_ZONES); i++) begin
            trip[i] = (cnt_q[i] == CNT_MAX);
        end
    end

    assign any_warm = |warm_q;
    assign any_hot  = |hot_q;
    assign any_trip = |trip;
    assign tick     = (tick_cnt_q == TICK_LAST);

`ifdef FA_MANUAL_CALL_EN
    logic manual_call_q, manual_flag_q;

    assign man_rise    = manual_call & ~manual_call_q;
    assign manual_flag = manual_flag_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            manual_call_q <= 1'b0;
            manual_flag_q <= 1'b0;
        end else begin
            manual_call_q <= manual_call;
            if (enter_idle) begin
                manual_flag_q <= 1'b0;
            end else if (man_rise && (state_q == ST_IDLE || state_q == ST_WARN)) begin
                manual_flag_q <= 1'b1;
            end
        end
    end
`else
    assign man_rise = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        countdown_d = countdown_q;
        case (state_q)
            ST_IDLE: begin
                if (any_trip || man_rise) state_d = ST_ALARM;
                else if (any_warm)        state_d = ST_WARN;
            end
            ST_WARN: begin
                if (any_trip || man_rise) state_d = ST_ALARM;
                else if (!any_warm)       state_d = ST_IDLE;
            end
            ST_ALARM: begin
                if (tick && countdown_q == 8'd1) begin
                    state_d     = ST_EVAC;
                    countdown_d = 8'd0;
                end else if (tick) begin
                    if (countdown_q != 8'd0) countdown_d = countdown_q - 8'd1;
                end else if (ack && !any_hot) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (ack && !any_hot) state_d = ST_IDLE;
            end
        endcase

        enter_alarm = (state_d == ST_ALARM) && (state_q == ST_IDLE || state_q == ST_WARN);
        enter_idle  = (state_d == ST_IDLE) && (state_q != ST_IDLE);
        if (enter_alarm || enter_idle) countdown_d = CD_LOAD;

        // Trips accumulate from the ALARM entry edge onwards, including through EVAC.
        if (enter_idle)      alarm_zone_d = '0;
        else if (state_d[1]) alarm_zone_d = alarm_zone_q | trip;
        else                 alarm_zone_d = alarm_zone_q;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            countdown_q  <= CD_LOAD;
            alarm_zone_q <= '0;
        end else begin
            state_q      <= state_d;
            countdown_q  <= countdown_d;
            alarm_zone_q <= alarm_zone_d;
        end
    end

    // Clearing on ALARM entry puts the first decrement exactly TICK_DIV cycles later.
    always_ff @(posedge clk_in) begin
        if (reset || enter_alarm || tick) tick_cnt_q <= '0;
        else                              tick_cnt_q <= tick_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (enter_alarm) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            led_q    <= 1'b0;
            buzzer_q <= 1'b0;
            evac_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:  begin led_q <= 1'b0;    buzzer_q <= 1'b0;    evac_q <= 1'b0; end
                ST_WARN:  begin led_q <= 1'b1;    buzzer_q <= 1'b0;    evac_q <= 1'b0; end
                ST_ALARM: begin led_q <= phase_q; buzzer_q <= phase_q; evac_q <= 1'b0; end
                default:  begin led_q <= phase_q; buzzer_q <= 1'b1;    evac_q <= 1'b1; end
            endcase
        end
    end

    assign state      = state_q;
    assign alarm_zone = alarm_zone_q;
    assign countdown  = countdown_q;
    assign led_out    = led_q;
    assign buzzer_out = buzzer_q;
    assign evac_out   = evac_q;

endmodule

// File: tb/tb_fire_alarm_zone_controller.sv
// Scoreboard bench for fire_alarm_zone_controller: stimulus schedules expected values by cycle,
// a negedge monitor pops and compares them. Manual-call checks run when FA_MANUAL_CALL_EN is set.
module tb_fire_alarm_zone_controller;

    localparam int NZ = 4;

    localparam int F_STATE = 0;
    localparam int F_AZ    = 1;
    localparam int F_CD    = 2;
    localparam int F_LED   = 3;
    localparam int F_BUZ   = 4;
    localparam int F_EVAC  = 5;
    localparam int F_MF    = 6;

    typedef struct {
        int at;
        int id;
        int val;
    } exp_t;

    logic            clk_in = 1'b0;
    logic            reset  = 1'b1;
    logic [NZ*8-1:0] temp_in = '0;
    logic [NZ-1:0]   temp_valid = '0;
    logic            ack = 1'b0;
    logic [1:0]      state;
    logic [NZ-1:0]   alarm_zone;
    logic [7:0]      countdown;
    logic            led_out, buzzer_out, evac_out;
`ifdef FA_MANUAL_CALL_EN
    logic            manual_call = 1'b0;
    logic            manual_flag;
`endif

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    fire_alarm_zone_controller #(
        .NUM_ZONES  (NZ),
        .TEMP_W     (8),
        .WARN_TH    (40),
        .ALARM_TH   (50),
        .CONFIRM_N  (3),
        .COUNTDOWN_S(3),
        .TICK_DIV   (10),
        .BLINK_DIV  (5)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .temp_in    (temp_in),
        .temp_valid (temp_valid),
        .ack        (ack),
`ifdef FA_MANUAL_CALL_EN
        .manual_call(manual_call),
        .manual_flag(manual_flag),
`endif
        .state      (state),
        .alarm_zone (alarm_zone),
        .countdown  (countdown),
        .led_out    (led_out),
        .buzzer_out (buzzer_out),
        .evac_out   (evac_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int id);
        case (id)
            F_STATE: return 32'(state);
            F_AZ:    return 32'(alarm_zone);
            F_CD:    return 32'(countdown);
            F_LED:   return 32'(led_out);
            F_BUZ:   return 32'(buzzer_out);
            F_EVAC:  return 32'(evac_out);
`ifdef FA_MANUAL_CALL_EN
            F_MF:    return 32'(manual_flag);
`endif
            default: return 32'hffff_ffff;
        endcase
    endfunction

    function automatic string fname(input int id);
        case (id)
            F_STATE: return "state";
            F_AZ:    return "alarm_zone";
            F_CD:    return "countdown";
            F_LED:   return "led_out";
            F_BUZ:   return "buzzer_out";
            F_EVAC:  return "evac_out";
            default: return "manual_flag";
        endcase
    endfunction

    // Monitor: compare every expectation due at this cycle; late ones count as errors.
    always @(negedge clk_in) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at <= cyc) begin
                logic [31:0] a;
                a = actual(exp_q[i].id);
                checks++;
                if (exp_q[i].at < cyc || a !== 32'(exp_q[i].val)) begin
                    errors++;
                    $display("FAIL %s at cycle %0d (due %0d): got %0d, want %0d",
                             fname(exp_q[i].id), cyc, exp_q[i].at, a, exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
    end

    task automatic expect_at(input int d, input int id, input int v);
        exp_t e;
        e.at  = cyc + d;
        e.id  = id;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send(input int z, input int v);
        temp_in[z*8 +: 8] = 8'(v);
        temp_valid        = '0;
        temp_valid[z]     = 1'b1;
        step(1);
        temp_valid        = '0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(2);
        reset = 1'b0;
        expect_at(0, F_STATE, 0);
        expect_at(0, F_AZ, 0);
        expect_at(0, F_CD, 3);
        expect_at(0, F_LED, 0);
        expect_at(0, F_BUZ, 0);
        expect_at(0, F_EVAC, 0);
        step(2);

        // Zone 2 trips after three hot samples, then counts down into EVAC.
        send(2, 55);
        expect_at(1, F_STATE, 1);
        send(2, 55);
        send(2, 55);
        expect_at(1, F_STATE, 2);
        expect_at(1, F_AZ, 4);
        expect_at(1, F_CD, 3);
        expect_at(1, F_BUZ, 0);
        expect_at(2, F_BUZ, 1);
        expect_at(6, F_BUZ, 1);
        expect_at(7, F_BUZ, 0);
        expect_at(7, F_LED, 0);
        expect_at(12, F_LED, 1);
        expect_at(10, F_CD, 3);
        expect_at(11, F_CD, 2);
        expect_at(20, F_CD, 2);
        expect_at(21, F_CD, 1);
        expect_at(30, F_STATE, 2);
        expect_at(31, F_STATE, 3);
        expect_at(31, F_CD, 0);
        expect_at(31, F_EVAC, 0);
        expect_at(32, F_EVAC, 1);
        expect_at(32, F_BUZ, 1);
        step(33);

        // Ack ignored while zone 2 is hot; accepted once it cools.
        pulse_ack();
        expect_at(0, F_STATE, 3);
        send(2, 20);
        pulse_ack();
        expect_at(0, F_STATE, 0);
        expect_at(0, F_AZ, 0);
        expect_at(0, F_CD, 3);
        expect_at(1, F_EVAC, 0);
        expect_at(1, F_BUZ, 0);
        step(3);

        // Warm zone 0 gives WARN; interrupted hot run must not trip.
        send(0, 45);
        expect_at(1, F_STATE, 1);
        expect_at(2, F_LED, 1);
        expect_at(2, F_BUZ, 0);
        send(0, 30);
        expect_at(1, F_STATE, 0);
        expect_at(2, F_LED, 0);
        step(3);
        send(0, 55);
        send(0, 55);
        send(0, 30);
        send(0, 55);
        send(0, 55);
        expect_at(1, F_STATE, 1);
        expect_at(3, F_STATE, 1);
        expect_at(3, F_AZ, 0);
        step(4);
        send(0, 30);
        step(2);
        expect_at(0, F_STATE, 0);
        step(2);

        // ALARM: ack while hot ignored; ack coincident with a zone 1 trip keeps ALARM.
        send(2, 55);
        send(2, 55);
        send(2, 55);
        expect_at(1, F_STATE, 2);
        step(1);
        pulse_ack();
        expect_at(0, F_STATE, 2);
        send(2, 20);
        send(1, 55);
        send(1, 55);
        send(1, 55);
        pulse_ack();
        expect_at(0, F_STATE, 2);
        expect_at(0, F_AZ, 6);
        expect_at(0, F_CD, 3);
        send(1, 20);
        pulse_ack();
        expect_at(0, F_STATE, 0);
        expect_at(0, F_AZ, 0);
        step(3);

        // Reset mid-countdown aborts to IDLE with reset values.
        send(2, 55);
        send(2, 55);
        send(2, 55);
        step(15);
        expect_at(0, F_STATE, 2);
        expect_at(0, F_CD, 2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        expect_at(0, F_STATE, 0);
        expect_at(0, F_CD, 3);
        expect_at(0, F_AZ, 0);
        expect_at(0, F_LED, 0);
        expect_at(0, F_BUZ, 0);
        expect_at(0, F_EVAC, 0);
        step(3);
        expect_at(0, F_STATE, 0);
        step(2);

`ifdef FA_MANUAL_CALL_EN
        manual_call = 1'b1;
        step(3);
        expect_at(0, F_STATE, 2);
        expect_at(0, F_MF, 1);
        expect_at(0, F_AZ, 0);
        step(1);
        pulse_ack();
        expect_at(0, F_STATE, 0);
        expect_at(0, F_MF, 0);
        manual_call = 1'b0;
        step(2);
`endif

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) step(1);
        if (exp_q.size() > 0) begin
            $display("FAIL scoreboard: got %0d pending expectations, want 0", exp_q.size());
            errors += exp_q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
